// File: rtl/pipeline_drain.sv
// pipeline_drain: credit-gated issue into a fixed-latency pipeline with an in-order result FIFO
module pipeline_drain #(
  parameter int VALUE_SIZE = 32,
  parameter int DELAY      = 4,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  pipe_issue,
  input  logic [VALUE_SIZE-1:0] pipe_result,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [VALUE_SIZE-1:0] m_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(DELAY + 1);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + DELAY + 1);
  logic [DELAY-1:0]      vsr;
  logic [IW-1:0]         inflight;
  logic [OW-1:0]         occ;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [VALUE_SIZE-1:0] mem [DEPTH];
  logic                  wr;
  logic                  pop;
  assign wr         = vsr[DELAY-1];
  assign pop        = m_valid & m_ready;
  assign m_valid    = occ != '0;
  assign s_ready    = (SW'(occ) + SW'(inflight)) < SW'(DEPTH);
  assign pipe_issue = s_valid & s_ready;
  assign m_data     = mem[rd_ptr];
  // Tag shift register, credit counters and FIFO pointers; clearing vsr makes late pipeline outputs harmless
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vsr      <= '0;
      inflight <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      vsr      <= (vsr << 1) | DELAY'(pipe_issue);
      inflight <= inflight + IW'(pipe_issue) - IW'(wr);
      occ      <= occ + OW'(wr) - OW'(pop);
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  // Result capture into unreset storage
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= pipe_result;
  // Each issue reserved a slot, so a write into a full FIFO means the credit logic is broken
  always_ff @(posedge clk)
    if (!reset && wr && !pop) assert (occ < OW'(DEPTH));
endmodule

// File: tb/tb_pipeline_drain.sv
// tb_pipeline_drain: directed and random checks of pipeline_drain across three DELAY/DEPTH configurations
module tb_pipeline_drain;
  localparam int DL [3] = '{4, 1, 7};
  localparam int DP [3] = '{8, 2, 4};
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid [3];
  logic        s_ready [3];
  logic        pipe_issue [3];
  logic        m_valid [3];
  logic        m_ready [3];
  logic [31:0] in_data [3];
  logic [31:0] pipe_result [3];
  logic [31:0] m_data [3];
  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int D = DL[g];
    logic [31:0] dq [D];
    // Free-running pipeline model: input value reappears exactly D cycles later
    always @(posedge clk) begin
      dq[0] <= in_data[g];
      for (int i = 1; i < D; i++) dq[i] <= dq[i-1];
    end
    assign pipe_result[g] = dq[D-1];
    pipeline_drain #(.VALUE_SIZE(32), .DELAY(DL[g]), .DEPTH(DP[g])) dut (
      .clk(clk),
      .reset(reset),
      .s_valid(s_valid[g]),
      .s_ready(s_ready[g]),
      .pipe_issue(pipe_issue[g]),
      .pipe_result(pipe_result[g]),
      .m_valid(m_valid[g]),
      .m_ready(m_ready[g]),
      .m_data(m_data[g])
    );
  end

  function automatic logic [31:0] rv(int k, int n);
    return n * 32'h9E3779B9 + k;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    for (int i = 0; i < 3; i++) begin
      s_valid[i] = 1'b0;
      m_ready[i] = 1'b0;
      in_data[i] = '0;
    end
  endtask

  task automatic test_reset;
    idle_all();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    s_valid[0] = 1'b1;
    in_data[0] = 32'h11;
    cyc();
    s_valid[0] = 1'b0;
    repeat (5) cyc();
    total++;
    if (m_valid[0] !== 1'b1) $display("FAIL reset_setup m_valid got %b want 1", m_valid[0]); else pass_cnt++;
    s_valid[0] = 1'b1;
    #2 reset = 1'b1;
    #1;
    total++;
    if (m_valid[0] !== 1'b0) $display("FAIL reset_async m_valid got %b want 0", m_valid[0]); else pass_cnt++;
    total++;
    if (s_ready[0] !== 1'b1) $display("FAIL reset_async s_ready got %b want 1", s_ready[0]); else pass_cnt++;
    total++;
    if (pipe_issue[0] !== 1'b1) $display("FAIL reset_async pipe_issue got %b want 1", pipe_issue[0]); else pass_cnt++;
    s_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      total++;
      if (m_valid[0] !== 1'b0) $display("FAIL reset_hold m_valid c=%0d got %b want 0", c, m_valid[0]); else pass_cnt++;
      total++;
      if (s_ready[0] !== 1'b1) $display("FAIL reset_hold s_ready c=%0d got %b want 1", c, s_ready[0]); else pass_cnt++;
    end
    reset = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_single;
    for (int c = 0; c < 10; c++) begin
      s_valid[0] = (c == 0);
      in_data[0] = 32'h3F800000;
      m_ready[0] = 1'b1;
      @(negedge clk);
      total++;
      if (m_valid[0] !== (c == 5)) $display("FAIL single m_valid c=%0d got %b want %b", c, m_valid[0], c == 5); else pass_cnt++;
      if (c == 5) begin
        total++;
        if (m_data[0] !== 32'h3F800000) $display("FAIL single m_data got %h want 3f800000", m_data[0]); else pass_cnt++;
      end
      total++;
      if (s_ready[0] !== 1'b1) $display("FAIL single s_ready c=%0d got %b want 1", c, s_ready[0]); else pass_cnt++;
      cyc();
    end
  endtask

  task automatic test_stream;
    for (int c = 0; c < 110; c++) begin
      s_valid[0] = (c < 100);
      in_data[0] = 32'(c);
      m_ready[0] = 1'b1;
      @(negedge clk);
      if (c < 100) begin
        total++;
        if (s_ready[0] !== 1'b1) $display("FAIL stream s_ready c=%0d got %b want 1", c, s_ready[0]); else pass_cnt++;
      end
      total++;
      if (m_valid[0] !== (c >= 5 && c <= 104)) $display("FAIL stream m_valid c=%0d got %b want %b", c, m_valid[0], c >= 5 && c <= 104); else pass_cnt++;
      if (c >= 5 && c <= 104) begin
        total++;
        if (m_data[0] !== 32'(c - 5)) $display("FAIL stream m_data c=%0d got %h want %h", c, m_data[0], 32'(c - 5)); else pass_cnt++;
      end
      cyc();
    end
    s_valid[0] = 1'b0;
  endtask

  task automatic test_backpressure;
    for (int c = 0; c < 30; c++) begin
      s_valid[0] = (c < 20);
      in_data[0] = 32'h100 + 32'(c);
      m_ready[0] = (c >= 20);
      @(negedge clk);
      total++;
      if (s_ready[0] !== (c < 8 || c >= 21)) $display("FAIL bp s_ready c=%0d got %b want %b", c, s_ready[0], c < 8 || c >= 21); else pass_cnt++;
      total++;
      if (pipe_issue[0] !== (c < 8)) $display("FAIL bp pipe_issue c=%0d got %b want %b", c, pipe_issue[0], c < 8); else pass_cnt++;
      total++;
      if (m_valid[0] !== (c >= 5 && c <= 27)) $display("FAIL bp m_valid c=%0d got %b want %b", c, m_valid[0], c >= 5 && c <= 27); else pass_cnt++;
      if (c >= 20 && c <= 27) begin
        total++;
        if (m_data[0] !== 32'h100 + 32'(c - 20)) $display("FAIL bp m_data c=%0d got %h want %h", c, m_data[0], 32'h100 + 32'(c - 20)); else pass_cnt++;
      end
      cyc();
    end
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b0;
  endtask

  task automatic test_reset_midflight;
    for (int c = 0; c < 21; c++) begin
      s_valid[0] = (c < 5) || (c == 9);
      in_data[0] = (c == 9) ? 32'hAA : 32'h200 + 32'(c);
      m_ready[0] = (c >= 9);
      if (c == 6) begin
        total++;
        if (m_valid[0] !== 1'b1) $display("FAIL midflight_setup m_valid got %b want 1", m_valid[0]); else pass_cnt++;
        reset = 1'b1;
      end
      @(negedge clk);
      if (c >= 6) begin
        total++;
        if (m_valid[0] !== (c == 14)) $display("FAIL midflight m_valid c=%0d got %b want %b", c, m_valid[0], c == 14); else pass_cnt++;
        total++;
        if (s_ready[0] !== 1'b1) $display("FAIL midflight s_ready c=%0d got %b want 1", c, s_ready[0]); else pass_cnt++;
      end
      if (c == 14) begin
        total++;
        if (m_data[0] !== 32'hAA) $display("FAIL midflight m_data got %h want 000000aa", m_data[0]); else pass_cnt++;
      end
      if (c == 6) reset = 1'b0;
      cyc();
    end
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b0;
  endtask

  task automatic test_random;
    int issued [3];
    int popped [3];
    int n;
    idle_all();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issued[i] = 0;
      popped[i] = 0;
    end
    n = 0;
    while ((popped[0] < 2000 || popped[1] < 2000 || popped[2] < 2000) && n < 30000) begin
      for (int i = 0; i < 3; i++) begin
        s_valid[i] = (issued[i] < 2000) && ($urandom_range(1) == 1);
        in_data[i] = rv(i, issued[i]);
        m_ready[i] = ($urandom_range(1) == 1);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (issued[i] - popped[i] > DP[i]) $display("FAIL random%0d outstanding got %0d want <= %0d", i, issued[i] - popped[i], DP[i]); else pass_cnt++;
        if (m_valid[i] && m_ready[i]) begin
          total++;
          if (m_data[i] !== rv(i, popped[i])) $display("FAIL random%0d m_data item %0d got %h want %h", i, popped[i], m_data[i], rv(i, popped[i])); else pass_cnt++;
          popped[i]++;
        end
        if (pipe_issue[i]) issued[i]++;
      end
      cyc();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (popped[i] !== 2000) $display("FAIL random%0d drained got %0d want 2000", i, popped[i]); else pass_cnt++;
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
